dtmr: RTL and testbench

Dynamic triple-modular-redundancy speed/direction controller for a sensor-guarded drive path. It sits between the command source (speed, direction, operating mode) and the motor driver. It runs a single processing lane while the reported error rate is low and switches to three voted lanes when the error rate rises. Faults are injected internally and deterministically, so redundancy and fault reporting are exercisable in simulation.

---
 rtl/dtmr_pkg.sv | 27 ++
 rtl/dtmr_lane.sv | 48 ++++
 rtl/dtmr.sv | 137 +++++++++++++
 tb/tb_dtmr.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dtmr_pkg.sv
// ============================================================================
// Module      : dtmr_pkg
// Description : Shared encodings and constants for the dtmr controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dtmr_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_HYBRID = 2'd1,
        MODE_MANUAL = 2'd2,
        MODE_SLEEP  = 2'd3
    } mode_t;

    typedef enum logic [0:0] {
        ST_SIMPLEX = 1'b0,
        ST_TMR     = 1'b1
    } state_t;

    localparam logic [7:0] c_corrupt_mask = 8'h55;
    localparam logic [3:0] c_lfsr_seed    = 4'b0001;

endpackage

`default_nettype wire

// File: rtl/dtmr_lane.sv
// ============================================================================
// Module      : dtmr_lane
// Description : Combinational speed/direction lane with obstacle guarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtmr_lane
    import dtmr_pkg::*;
(
    input  logic [3:0] i_speed,
    input  logic [3:0] i_dir,
    input  logic [1:0] i_mode,
    input  logic       i_f1,
    input  logic       i_f2,
    input  logic       i_b1,
    input  logic       i_b2,
    output logic [3:0] o_speed,
    output logic [3:0] o_dir
);

    logic w_front;
    logic w_back;
    logic w_blocked;

    // Sensors are active low; only the obstacle ahead of travel matters.
    assign w_front   = ~i_f1 | ~i_f2;
    assign w_back    = ~i_b1 | ~i_b2;
    assign w_blocked = i_dir[3] ? w_back : w_front;

    always_comb begin
        o_speed = i_speed;
        o_dir   = i_dir;
        case (mode_t'(i_mode))
            MODE_AUTO:   o_speed = w_blocked ? 4'd0 : i_speed;
            MODE_HYBRID: o_speed = w_blocked ? (i_speed >> 1) : i_speed;
            MODE_MANUAL: o_speed = i_speed;
            MODE_SLEEP: begin
                o_speed = 4'd0;
                o_dir   = 4'd0;
            end
            default:     o_speed = i_speed;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dtmr.sv
// ============================================================================
// Module      : dtmr
// Description : Dynamic TMR speed/direction controller with internal fault
//               injection, majority voter and simplex/TMR state machine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtmr
    import dtmr_pkg::*;
#(
    parameter int ERR_THRESH  = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] speed,
    input  logic [3:0] dir,
    input  logic [1:0] mode,
    input  logic [3:0] err_rate,
    input  logic       f1,
    input  logic       f2,
    input  logic       b1,
    input  logic       b2,
    output logic [3:0] speed_o,
    output logic [3:0] dir_o,
    output logic [2:0] fault,
    output logic       state_o
);

    localparam logic [3:0] c_thresh    = 4'(ERR_THRESH);
    localparam logic [1:0] c_hold_last = 2'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_hold;
    logic [3:0] r_lfsr;

    logic [7:0] w_lane_raw [3];
    logic [7:0] w_lane     [3];
    logic [7:0] w_vote;
    logic [2:0] w_fault;
    logic       w_inject;
    logic [1:0] w_target;
    logic       w_high_err;
    logic       w_sleep;

    assign w_inject   = (err_rate != 4'd0) && (r_lfsr < err_rate);
    assign w_target   = r_lfsr[1:0];
    assign w_high_err = (err_rate >= c_thresh);
    assign w_sleep    = (mode_t'(mode) == MODE_SLEEP);

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_lane
            dtmr_lane u_lane (
                .i_speed (speed),
                .i_dir   (dir),
                .i_mode  (mode),
                .i_f1    (f1),
                .i_f2    (f2),
                .i_b1    (b1),
                .i_b2    (b2),
                .o_speed (w_lane_raw[g][7:4]),
                .o_dir   (w_lane_raw[g][3:0])
            );
            // Target value 3 matches no lane, so that slot is fault-free.
            assign w_lane[g] = w_lane_raw[g] ^
                ((w_inject && (w_target == 2'(g))) ? c_corrupt_mask : 8'h00);
        end
    endgenerate

    assign w_vote = (w_lane[0] & w_lane[1]) |
                    (w_lane[0] & w_lane[2]) |
                    (w_lane[1] & w_lane[2]);

    always_comb begin
        w_fault = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_fault[i] = (w_lane[i] != w_vote);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_SIMPLEX;
            r_hold  <= 2'd0;
            r_lfsr  <= c_lfsr_seed;
            speed_o <= 4'd0;
            dir_o   <= 4'd0;
            fault   <= 3'b000;
        end else begin
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

            // Output selection uses the state held before this edge.
            if (r_state == ST_TMR) begin
                speed_o <= w_vote[7:4];
                dir_o   <= w_vote[3:0];
                fault   <= w_fault;
            end else begin
                speed_o <= w_lane[0][7:4];
                dir_o   <= w_lane[0][3:0];
                fault   <= 3'b000;
            end

            case (r_state)
                ST_SIMPLEX: begin
                    r_hold <= 2'd0;
                    if (w_high_err && !w_sleep) begin
                        r_state <= ST_TMR;
                    end
                end
                ST_TMR: begin
                    if (w_sleep) begin
                        r_state <= ST_SIMPLEX;
                        r_hold  <= 2'd0;
                    end else if (w_high_err) begin
                        r_hold <= 2'd0;
                    end else if (r_hold == c_hold_last) begin
                        r_state <= ST_SIMPLEX;
                        r_hold  <= 2'd0;
                    end else begin
                        r_hold <= r_hold + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_SIMPLEX;
                    r_hold  <= 2'd0;
                end
            endcase
        end
    end

    assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_dtmr.sv
// ============================================================================
// Module      : tb_dtmr
// Description : Self-checking bench for dtmr: cycle model plus directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dtmr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] speed = 4'd0;
    logic [3:0] dir = 4'd0;
    logic [1:0] mode = 2'd0;
    logic [3:0] err_rate = 4'd0;
    logic       f1 = 1'b1, f2 = 1'b1, b1 = 1'b1, b2 = 1'b1;
    logic [3:0] speed_o;
    logic [3:0] dir_o;
    logic [2:0] fault;
    logic       state_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit valid = 1'b0;

    dtmr #(.ERR_THRESH(8), .HOLD_CYCLES(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .speed    (speed),
        .dir      (dir),
        .mode     (mode),
        .err_rate (err_rate),
        .f1       (f1),
        .f2       (f2),
        .b1       (b1),
        .b2       (b2),
        .speed_o  (speed_o),
        .dir_o    (dir_o),
        .fault    (fault),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer arithmetic over the three lane values.
    int m_lfsr = 1;
    int m_tmr = 0;
    int m_hold = 0;
    int e_speed = 0, e_dir = 0, e_fault = 0, e_state = 0;

    always @(posedge clk or negedge rst) begin
        int blk, ls, ld, tgt, cnt, voted;
        int lanes [3];
        if (!rst) begin
            m_lfsr = 1; m_tmr = 0; m_hold = 0;
            e_speed = 0; e_dir = 0; e_fault = 0; e_state = 0;
        end else begin
            blk = dir[3] ? int'(!b1 || !b2) : int'(!f1 || !f2);
            ls = speed;
            ld = dir;
            case (mode)
                2'd0: ls = blk ? 0 : speed;
                2'd1: ls = blk ? speed / 2 : speed;
                2'd2: ls = speed;
                default: begin ls = 0; ld = 0; end
            endcase
            for (int i = 0; i < 3; i++) lanes[i] = ls * 16 + ld;
            tgt = m_lfsr % 4;
            if (err_rate != 0 && m_lfsr < int'(err_rate) && tgt != 3)
                lanes[tgt] = lanes[tgt] ^ 'h55;
            if (m_tmr == 1) begin
                voted = 0;
                for (int b = 0; b < 8; b++) begin
                    cnt = 0;
                    for (int i = 0; i < 3; i++) cnt += (lanes[i] >> b) & 1;
                    if (cnt >= 2) voted += (1 << b);
                end
                e_fault = 0;
                for (int i = 0; i < 3; i++)
                    if (lanes[i] != voted) e_fault += (1 << i);
            end else begin
                voted = lanes[0];
                e_fault = 0;
            end
            e_speed = voted / 16;
            e_dir = voted % 16;
            if (mode == 2'd3) begin
                m_tmr = 0; m_hold = 0;
            end else if (err_rate >= 8) begin
                m_tmr = 1; m_hold = 0;
            end else if (m_tmr == 1) begin
                m_hold++;
                if (m_hold == 4) begin m_tmr = 0; m_hold = 0; end
            end else begin
                m_hold = 0;
            end
            e_state = m_tmr;
            m_lfsr = ((m_lfsr * 2) % 16) | (((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1);
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            check("model_speed_o", speed_o, e_speed);
            check("model_dir_o", dir_o, e_dir);
            check("model_fault", fault, e_fault);
            check("model_state_o", state_o, e_state);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic sensors(input logic [3:0] s);
        {f1, f2, b1, b2} = s;
    endtask

    initial begin
        #12;
        check("reset_speed_o", speed_o, 0);
        check("reset_dir_o", dir_o, 0);
        check("reset_fault", fault, 0);
        check("reset_state_o", state_o, 0);
        tick();
        rst = 1'b1;
        valid = 1'b1;

        // Auto mode guarding and clearing.
        mode = 2'd0; err_rate = 4'd0; dir = 4'h1; speed = 4'd5; sensors(4'b0111);
        tick();
        check("auto_blocked_speed", speed_o, 0);
        check("auto_blocked_dir", dir_o, 1);
        sensors(4'b1111);
        tick();
        check("auto_clear_speed", speed_o, 5);

        // Hybrid reverse: back obstacle halves, front obstacle is ignored.
        mode = 2'd1; dir = 4'h9; speed = 4'd6; sensors(4'b1110);
        tick();
        check("hybrid_back_speed", speed_o, 3);
        check("hybrid_back_dir", dir_o, 9);
        sensors(4'b0111);
        tick();
        check("hybrid_front_speed", speed_o, 6);

        // Manual ignores sensors; sleep zeroes everything.
        mode = 2'd2; speed = 4'd9; sensors(4'b0000);
        tick();
        check("manual_speed", speed_o, 9);
        mode = 2'd3;
        tick();
        check("sleep_speed", speed_o, 0);
        check("sleep_dir", dir_o, 0);

        // Enter TMR and hold the voted value despite injection.
        mode = 2'd0; err_rate = 4'd10; speed = 4'd7; dir = 4'h1; sensors(4'b1111);
        tick();
        check("tmr_enter_state", state_o, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("tmr_speed", speed_o, 7);
            check("tmr_dir", dir_o, 1);
            check("tmr_fault_onehot", int'($countones(fault) <= 1), 1);
        end

        // Exit after four clean edges.
        err_rate = 4'd0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("tmr_exit_state", state_o, (i < 4) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_exit_fault", fault, 0);
            check("post_exit_speed", speed_o, 7);
        end

        // Sleep wins over a high error rate.
        err_rate = 4'd10;
        tick();
        check("reenter_state", state_o, 1);
        mode = 2'd3;
        tick();
        check("sleep_wins_state", state_o, 0);
        check("sleep_wins_speed", speed_o, 0);
        tick();
        check("sleep_stays_simplex", state_o, 0);

        // Asynchronous reset while in TMR.
        mode = 2'd0;
        tick();
        tick();
        check("pre_reset_state", state_o, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_speed", speed_o, 0);
        check("async_rst_dir", dir_o, 0);
        check("async_rst_fault", fault, 0);
        check("async_rst_state", state_o, 0);
        err_rate = 4'd7; speed = 4'd7; dir = 4'h1;
        tick();
        rst = 1'b1;
        // LFSR restarts at 1,2,4: only the third edge corrupts lane 0.
        tick();
        check("restart_e1_speed", speed_o, 7);
        check("restart_e1_state", state_o, 0);
        tick();
        check("restart_e2_speed", speed_o, 7);
        tick();
        check("restart_e3_speed", speed_o, 2);
        check("restart_e3_dir", dir_o, 4);
        tick();
        check("restart_e4_speed", speed_o, 7);

        tick();
        valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
